// File: rtl/seq_shift_unit_pkg.sv
// Shared types for the sequential shift/rotate unit: operation encoding and FSM states.
package seq_shift_unit_pkg;

   typedef enum logic [1:0] {
      OP_SLL  = 2'd0,
      OP_SRL  = 2'd1,
      OP_SRA  = 2'd2,
      OP_ROTR = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned AMT_W  = 5;

endpackage

// File: rtl/seq_shift_unit_shift_step.sv
// One combinational shift/rotate step of 1 or 2 bit positions, with the last bit pushed out.
module seq_shift_unit_shift_step
   import seq_shift_unit_pkg::*;
(
   input  logic [31:0] word,
   input  op_t         op,
   input  logic        two,
   output logic [31:0] next_word,
   output logic        bit_out
);

   logic fill;

   // The bit out is the one that crosses the word boundary last in a 2-bit step.
   always_comb begin
      next_word = word;
      bit_out   = 1'b0;
      fill      = (op == OP_SRA) ? word[31] : 1'b0;
      case (op)
         OP_SLL: begin
            if (two) begin
               next_word = {word[29:0], 2'b00};
               bit_out   = word[30];
            end else begin
               next_word = {word[30:0], 1'b0};
               bit_out   = word[31];
            end
         end
         OP_SRL, OP_SRA: begin
            if (two) begin
               next_word = {fill, fill, word[31:2]};
               bit_out   = word[1];
            end else begin
               next_word = {fill, word[31:1]};
               bit_out   = word[0];
            end
         end
         OP_ROTR: begin
            if (two) begin
               next_word = {word[1:0], word[31:2]};
               bit_out   = word[1];
            end else begin
               next_word = {word[0], word[31:1]};
               bit_out   = word[0];
            end
         end
         default: begin
            next_word = word;
            bit_out   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: moves the operand up to two bit positions per cycle.
module seq_shift_unit
   import seq_shift_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [4:0]  amt,
   input  logic [1:0]  op,
   output logic        busy,
   output logic        done,
   output logic [31:0] y,
   output logic        c_out
);

   state_t      state;
   op_t         op_q;
   logic [4:0]  remaining;
   logic        step_two;
   logic [31:0] step_word;
   logic        step_bit;

   assign step_two = (remaining >= 5'd2);

   seq_shift_unit_shift_step u_step (
      .word      (y),
      .op        (op_q),
      .two       (step_two),
      .next_word (step_word),
      .bit_out   (step_bit)
   );

   // y doubles as the working register, so it holds the result once the count runs out.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         op_q      <= OP_SLL;
         remaining <= 5'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         y         <= 32'd0;
         c_out     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  y         <= a;
                  remaining <= amt;
                  op_q      <= op_t'(op);
                  c_out     <= 1'b0;
                  busy      <= 1'b1;
                  if (amt == 5'd0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               y         <= step_word;
               c_out     <= step_bit;
               remaining <= remaining - (step_two ? 5'd2 : 5'd1);
               if (remaining <= 5'd2) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit with hand-computed results, latencies and pulse counts.
module tb_seq_shift_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] a;
   logic [4:0]  amt;
   logic [1:0]  op;
   logic        busy;
   logic        done;
   logic [31:0] y;
   logic        c_out;

   int checks;
   int failures;
   int done_pulses;

   seq_shift_unit dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .amt   (amt),
      .op    (op),
      .busy  (busy),
      .done  (done),
      .y     (y),
      .c_out (c_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every cycle in which done is high, sampled away from the rising edge.
   always @(negedge clk) begin
      if (done) done_pulses <= done_pulses + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] op_v, input logic [31:0] a_v, input logic [4:0] amt_v);
      start = 1'b1;
      a     = a_v;
      amt   = amt_v;
      op    = op_v;
   endtask

   task automatic runOp(input string tag, input logic [1:0] op_v, input logic [31:0] a_v,
                        input logic [4:0] amt_v, input logic [31:0] exp_y, input logic exp_c,
                        input int exp_lat, input bit disturb);
      int lat;
      int pulses_before;
      pulses_before = done_pulses;
      applyStimulus(op_v, a_v, amt_v);
      @(posedge clk); #1;
      start = 1'b0;
      a     = ~a_v;
      amt   = amt_v + 5'd7;
      op    = op_v + 2'd1;
      lat   = 1;
      while (!done && lat < 40) begin
         if (disturb && lat == 2) begin
            start = 1'b1;
            a     = 32'hFFFF_FFFF;
            amt   = 5'd3;
            op    = 2'd3;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      checkOutput({tag, "_y"}, y, exp_y);
      checkOutput({tag, "_c"}, {31'd0, c_out}, {31'd0, exp_c});
      repeat (3) @(posedge clk);
      #1;
      checkOutput({tag, "_hold_y"}, y, exp_y);
      checkOutput({tag, "_hold_c"}, {31'd0, c_out}, {31'd0, exp_c});
      checkOutput({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, "_pulses"}, 32'(done_pulses - pulses_before), 32'd1);
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      done_pulses = 0;
      reset = 1'b1;
      start = 1'b0;
      a     = 32'd0;
      amt   = 5'd0;
      op    = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_y", y, 32'd0);
      checkOutput("rst_c", {31'd0, c_out}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      runOp("sll31",   2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 17, 1'b0);
      runOp("rotr1",   2'd3, 32'h0000_0003, 5'd1,  32'h8000_0001, 1'b1, 2,  1'b0);
      runOp("sra4",    2'd2, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 3,  1'b0);
      runOp("srl4",    2'd1, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 3,  1'b0);
      runOp("srl0",    2'd1, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF, 1'b0, 1,  1'b0);
      runOp("sll3",    2'd0, 32'hF000_0000, 5'd3,  32'h8000_0000, 1'b1, 3,  1'b0);
      runOp("sll2",    2'd0, 32'h4000_0000, 5'd2,  32'h0000_0000, 1'b1, 2,  1'b0);
      runOp("rotr4",   2'd3, 32'h1234_5678, 5'd4,  32'h8123_4567, 1'b1, 3,  1'b0);
      runOp("sra31",   2'd2, 32'hC000_0001, 5'd31, 32'hFFFF_FFFF, 1'b1, 17, 1'b0);
      runOp("srl31",   2'd1, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 17, 1'b0);
      runOp("disturb", 2'd0, 32'h0000_0001, 5'd10, 32'h0000_0400, 1'b0, 6,  1'b1);

      // Start held high: second operation accepted after exactly one idle cycle.
      applyStimulus(2'd1, 32'h0000_0100, 5'd2);
      @(posedge clk); #1;
      a   = 32'h0000_000F;
      amt = 5'd1;
      op  = 2'd0;
      @(posedge clk); #1;
      checkOutput("b2b_done1", {31'd0, done}, 32'd1);
      checkOutput("b2b_y1", y, 32'h0000_0040);
      @(posedge clk); #1;
      checkOutput("b2b_idle", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      checkOutput("b2b_accept", {31'd0, busy}, 32'd1);
      start = 1'b0;
      @(posedge clk); #1;
      checkOutput("b2b_done2", {31'd0, done}, 32'd1);
      checkOutput("b2b_y2", y, 32'h0000_001E);
      repeat (3) @(posedge clk);
      #1;

      // Reset in the middle of a long operation aborts it without a done pulse.
      begin
         int pulses_before;
         pulses_before = done_pulses;
         applyStimulus(2'd1, 32'hFFFF_FFFF, 5'd20);
         @(posedge clk); #1;
         start = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         checkOutput("abort_busy_pre", {31'd0, busy}, 32'd1);
         reset = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0;
         checkOutput("abort_y", y, 32'd0);
         checkOutput("abort_c", {31'd0, c_out}, 32'd0);
         checkOutput("abort_busy", {31'd0, busy}, 32'd0);
         checkOutput("abort_done", {31'd0, done}, 32'd0);
         repeat (15) @(posedge clk);
         #1;
         checkOutput("abort_pulses", 32'(done_pulses - pulses_before), 32'd0);
      end
      runOp("after_rst", 2'd1, 32'hFFFF_FFFF, 5'd20, 32'h0000_0FFF, 1'b1, 11, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
